// File: rtl/swi_pkg.sv
// Shared types and default sizing for the switch-bank input conditioner.
package swi_pkg;

  localparam int NBITS_TOP       = 8;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int FIFO_DEPTH      = 4;
  localparam int SWI_IW          = $clog2(NBITS_TOP);

  typedef struct packed {
    logic [SWI_IW-1:0] idx;
    logic              level;
  } swi_event_t;

endpackage

// File: rtl/swi_event_fifo.sv
// Show-ahead event queue: the head entry is visible whenever the queue is non-empty.
module swi_event_fifo
  import swi_pkg::*;
#(
  parameter int  DEPTH  = swi_pkg::FIFO_DEPTH,
  parameter type elem_t = swi_pkg::swi_event_t,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic          clk_2,
  input  logic          rst_n,
  input  logic          push,
  input  elem_t         din,
  input  logic          pop,
  output elem_t         dout,
  output logic          valid,
  output logic          full,
  output logic [PW:0]   count
);

  elem_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  // When full, a same-cycle pop frees the head slot that the write lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_2) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/swi_debounce.sv
// Switch-bank conditioner: synchronise, debounce, edge pulses and a queued
// stream of per-bit change events consumed through valid/ready.
module swi_debounce
  import swi_pkg::*;
#(
  parameter int  NBITS_TOP       = swi_pkg::NBITS_TOP,
  parameter int  DEBOUNCE_CYCLES = swi_pkg::DEBOUNCE_CYCLES,
  parameter int  FIFO_DEPTH      = swi_pkg::FIFO_DEPTH,
  localparam int IW              = $clog2(NBITS_TOP),
  localparam int CW              = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1,
  localparam int QW              = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_2,
  input  logic                 rst_n,
  input  logic [NBITS_TOP-1:0] SWI_raw,
  output logic [NBITS_TOP-1:0] swi_clean,
  output logic [NBITS_TOP-1:0] rise,
  output logic [NBITS_TOP-1:0] fall,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [IW-1:0]        ev_idx,
  output logic                 ev_level,
  output logic [QW-1:0]        ev_count
);

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          level;
  } ev_t;

  logic [NBITS_TOP-1:0] sync1;
  logic [NBITS_TOP-1:0] s;
  logic [NBITS_TOP-1:0] clean_d;
  logic [NBITS_TOP-1:0] pending;
  logic [NBITS_TOP-1:0] chg;
  logic [NBITS_TOP-1:0] clr;
  logic [CW-1:0]        cnt [NBITS_TOP];
  logic [IW-1:0]        sel;
  logic                 any_pend;
  logic                 push;
  logic                 pop;
  logic                 q_full;
  ev_t                  push_ev;
  ev_t                  head;

  // A bit flips on the sample that completes a full run of disagreeing samples.
  always_comb begin
    chg = '0;
    for (int i = 0; i < NBITS_TOP; i++)
      chg[i] = (s[i] != swi_clean[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
  end

  always_comb begin
    sel = '0;
    for (int i = NBITS_TOP - 1; i >= 0; i--)
      if (pending[i]) sel = IW'(i);
  end

  assign any_pend      = |pending;
  assign pop           = ev_valid && ev_ready;
  assign push          = any_pend && (!q_full || pop);
  assign clr           = push ? (NBITS_TOP'(1) << sel) : '0;
  assign push_ev.idx   = sel;
  assign push_ev.level = swi_clean[sel];

  assign rise = swi_clean & ~clean_d;
  assign fall = ~swi_clean & clean_d;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      s         <= '0;
      swi_clean <= '0;
      clean_d   <= '0;
      pending   <= '0;
      for (int i = 0; i < NBITS_TOP; i++) cnt[i] <= '0;
    end else begin
      sync1     <= SWI_raw;
      s         <= sync1;
      swi_clean <= swi_clean ^ chg;
      clean_d   <= swi_clean;
      // A fresh change on the push edge keeps the bit pending for a later event.
      pending   <= (pending & ~clr) | chg;
      for (int i = 0; i < NBITS_TOP; i++) begin
        if ((s[i] == swi_clean[i]) || chg[i]) cnt[i] <= '0;
        else                                  cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  swi_event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .elem_t (ev_t)
  ) u_fifo (
    .clk_2 (clk_2),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_ev),
    .pop   (ev_ready),
    .dout  (head),
    .valid (ev_valid),
    .full  (q_full),
    .count (ev_count)
  );

  assign ev_idx   = head.idx;
  assign ev_level = head.level;

endmodule

// File: doc/swi_debounce.md
# swi_debounce

Input conditioner for the board switch bank: samples raw `SWI` levels from the simulator or pins, synchronises and debounces each bit, and produces clean levels, one-cycle rise/fall pulses, and a queued stream of change events. It sits between the raw switch inputs and `top`, which then uses `swi_clean` instead of raw `SWI`. Event consumers pop changes through a valid/ready handshake, so no transition is missed when the consumer is slow.

## Interface
- `NBITS_TOP`, 8: switch count; must be ≥2 and a power of two.
- `DEBOUNCE_CYCLES`, 4: consecutive stable samples required before a level is accepted; must be ≥1.
- `FIFO_DEPTH`, 4: event queue entries; must be a power of two and ≥2.

Ports (`IW = $clog2(NBITS_TOP)`):
- `clk_2`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `SWI_raw`  in  NBITS_TOP  unsynchronised switch levels.
- `swi_clean`  out  NBITS_TOP  debounced levels.
- `rise`, `fall`  out  NBITS_TOP  one-cycle pulses per bit when `swi_clean` goes 0→1 or 1→0.
- `ev_valid`  out  1  event queue non-empty.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_idx`  out  IW  bit index of the head event.
- `ev_level`  out  1  new level of that bit.
- `ev_count`  out  $clog2(FIFO_DEPTH)+1  queue occupancy.

## Operation
- Per bit, a 2-flop synchroniser produces `s[i]`.
- Per-bit counter `cnt[i]` with width `$clog2(DEBOUNCE_CYCLES)`, minimum 1 bit. On each edge:
  - if `s[i] != swi_clean[i]`: when `cnt == DEBOUNCE_CYCLES-1`, load `swi_clean[i] <= s[i]` and clear `cnt`; otherwise increment `cnt`.
  - if `s[i] == swi_clean[i]`: clear `cnt`. A glitch shorter than `DEBOUNCE_CYCLES` samples is discarded.
- `rise = swi_clean & ~clean_d` and `fall = ~swi_clean & clean_d`, where `clean_d` is `swi_clean` delayed one cycle.
- `pending[i]` is set on the edge where `swi_clean[i]` changes. A second change before the event is pushed coalesces into one event, and that event carries the then-current level.
- Arbiter: each cycle the lowest-index pending bit is pushed as `{idx, swi_clean[idx]}`, provided the queue is not full or a pop occurs in the same cycle. The pushed bit's `pending` is cleared unless it changes again on that same edge.
- When the queue is full, pending bits wait. No event is ever dropped, only coalesced.
- Queue is show-ahead:
  - `ev_idx` and `ev_level` are valid whenever `ev_valid` is high.
  - Pop occurs on `ev_valid && ev_ready`.
  - `ev_ready` while empty is ignored.
- Simultaneous push and pop: allowed at any occupancy, including full. `ev_count` is unchanged.

## Timing
- Reset values:
  - synchroniser flops, `swi_clean`, `clean_d`, `cnt`, `pending`, queue pointers: 0.
  - outputs `rise`, `fall`, `ev_valid`, `ev_count`: 0. `ev_idx` and `ev_level`: 0.
- Reset mid-operation: all state clears immediately and queued events are lost. After release, a bit held at 1 reports one rise event once debounced.
- Latency, for `SWI_raw` stable at its new value before edge k:
  - `s` changes after edge k+1.
  - `swi_clean` and the `rise`/`fall` pulse change after edge k+1+DEBOUNCE_CYCLES.
  - `ev_valid` rises after edge k+2+DEBOUNCE_CYCLES, provided the queue has space and no lower-index bit is pending.
- Throughput: one push and one pop per cycle.
- N bits changing on the same edge appear on N consecutive cycles in ascending index order.

## Structure
- Package `swi_pkg` holds:
  - `swi_event_t` typedef (`idx`, `level`).
  - the default constants `NBITS_TOP`, `DEBOUNCE_CYCLES`, `FIFO_DEPTH`.
- Sub-module `swi_event_fifo`: synchronous show-ahead FIFO of `swi_event_t` with push/pop/count. The debounce and arbiter logic live in `swi_debounce`.

## Test plan
- Reset with `SWI_raw=8'hFF` held:
  - all outputs are 0 during reset.
  - after release, `swi_clean` becomes 8'hFF 5 cycles after the first sampling edge (D=4).
  - 8 events follow, idx 0..7, level 1, with `ev_ready=1`.
- Glitch: `SWI_raw[3]` high for 3 cycles, then low → `swi_clean`, `rise` and `ev_valid` stay 0 throughout.
- Clean press: `SWI_raw[5]` 0→1 before edge k → `rise[5]` pulses exactly one cycle after edge k+5, then `ev_valid` with `ev_idx=5` and `ev_level=1` after edge k+6.
- Backpressure with `ev_ready=0`:
  - toggle bits 0..5 once each → `ev_count` saturates at 4.
  - raise `ev_ready` → 6 events in total, in ascending order, none lost.
- Coalescing: with the queue full, bit 2 goes 0→1 and then 1→0, each debounced → exactly one bit-2 event, `ev_level=0`.
- Full with simultaneous push/pop: `ev_ready=1` while full and bit 7 pending → `ev_count` stays 4 and the bit-7 event enters the queue in the same cycle.
